// File: rtl/data_mem_responder.sv
// Memory-side responder for the pipelined MIPS load/store port: accepts one word
// request at a time, waits LATENCY cycles, then returns load data or a store acknowledge.
module data_mem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0] COUNT_LOAD = CW'(LATENCY - 1);
   localparam logic [31:0]   LAST_WORD  = 32'(DEPTH - 4);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_count;
   logic          r_we;
   logic [31:0]   r_addr;
   logic [31:0]   r_wdata;
   logic [3:0]    r_be;
   logic          r_respValid;
   logic [31:0]   r_rdata;
   logic          r_err;

   logic [7:0]    mem_array [DEPTH];

   logic          w_access;
   logic          w_err;
   logic [AW-1:0] w_base;
   logic [31:0]   w_loadData;

   // The access happens on the edge that leaves BUSY, using only the captured request.
   assign w_access   = (r_state == BUSY) && (r_count == '0);
   assign w_err      = (r_addr[1:0] != 2'b00) || (r_addr > LAST_WORD);
   assign w_base     = r_addr[AW-1:0];
   assign w_loadData = {mem_array[w_base + AW'(3)], mem_array[w_base + AW'(2)],
                        mem_array[w_base + AW'(1)], mem_array[w_base]};

   assign req_ready  = (r_state == IDLE);
   assign resp_valid = r_respValid;
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_be        <= '0;
         r_respValid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we    <= req_we;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_be    <= req_be;
                  r_count <= COUNT_LOAD;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               if (r_count == '0) begin
                  r_state     <= RESP;
                  r_respValid <= 1'b1;
                  r_err       <= w_err;
                  r_rdata     <= (w_err || r_we) ? 32'h0 : w_loadData;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  r_state     <= IDLE;
                  r_respValid <= 1'b0;
                  r_rdata     <= '0;
                  r_err       <= 1'b0;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Storage has no reset; a reset during BUSY suppresses the pending store.
   always_ff @(posedge clk) begin
      if (rst && w_access && r_we && !w_err) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) begin
               mem_array[w_base + AW'(i)] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the pipelined MIPS CPU's load/store port.
- The CPU core initiates word requests; this block accepts them, waits a programmable latency, then returns data or a write acknowledge.
- Storage is a little-endian byte array named mem_array, one byte per entry, so the bench preloads it with $readmemh exactly as it does the single-cycle data memory.
- Lets the pipeline's stall logic be exercised against a non-zero-wait memory.

Parameters:
- DEPTH, 256, number of bytes in mem_array; must be a multiple of 4 and at least 4.
- LATENCY, 2, number of cycles spent in BUSY between request acceptance and response; must be at least 1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-low; takes effect on the rising edge while 0.
- req_valid  input  1  a request is presented.
- req_ready  output  1  the responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, little-endian.
- req_be  input  4  store byte enables; bit i selects byte i = req_wdata[8i+7:8i]; ignored for loads.
- resp_valid  output  1  response is presented.
- resp_ready  input  1  the CPU accepts the response.
- resp_rdata  output  32  load data, little-endian; 0 for stores and errors.
- resp_err  output  1  the request was misaligned or out of range.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, latency counter 0, captured request registers 0. req_ready is 1 the cycle after reset deasserts.
- mem_array is never cleared by reset; contents persist across reset.
- States: IDLE, BUSY, RESP.
- IDLE:
  - req_ready = 1.
  - On a rising edge with req_valid=1 (the accept), capture we, addr, wdata and be, load the counter, and go to BUSY.
- BUSY:
  - req_ready = 0.
  - Stay exactly LATENCY cycles, then go to RESP. resp_valid rises exactly LATENCY edges after the accepting edge.
- Entering RESP, on the edge the memory access is performed:
  - Error condition: addr[1:0] != 0, or addr > DEPTH-4. On error, mem_array is untouched, resp_err=1 and resp_rdata=0.
  - Load: resp_rdata = {mem[a+3], mem[a+2], mem[a+1], mem[a]}, resp_err=0.
  - Store: each byte with be[i]=1 is written to mem[a+i]; resp_rdata=0, resp_err=0. be=0000 is legal, writes nothing and still acknowledges.
- RESP:
  - resp_valid=1; resp_rdata and resp_err are held stable until a rising edge with resp_ready=1.
  - After that handshake edge, go to IDLE and clear resp_valid, resp_rdata and resp_err to 0.
- Throughput:
  - One outstanding request at most.
  - Minimum spacing between accepts is LATENCY+2 cycles: one accept cycle, LATENCY cycles of BUSY, one response cycle.
  - req_ready is never asserted in the same cycle as resp_valid.
- Request inputs are sampled only on the accept edge; changes during BUSY or RESP are ignored.
- Reset mid-operation: rst=0 in BUSY abandons the request and leaves memory unmodified. rst=0 in RESP drops the pending response. In both cases the block returns to IDLE with the reset values above.
- A store followed by a load of the same address returns the stored bytes. There is no forwarding hazard, because accesses are serialised.
- Address bits above the range check are not wrapped; any address above DEPTH-4 reports an error.

Test Plan:
- Preload mem[0..3]=78 56 34 12; load addr 0 with LATENCY=2 -> resp_valid rises 2 edges after accept; resp_rdata=32'h12345678, resp_err=0.
- Store addr 8, wdata 32'hAABBCCDD, be 4'b0101, with mem[8..11] initially 0; then load addr 8 -> resp_rdata=32'h00BB00DD.
- Load addr 6 (misaligned), then load addr DEPTH (out of range) -> resp_err=1 and resp_rdata=0 for both; no memory change.
- Hold resp_ready=0 for 5 cycles during RESP -> resp_valid, resp_rdata and resp_err held stable and req_ready=0 throughout; raise resp_ready -> IDLE on the next edge, req_ready=1.
- Issue a store of 32'hFFFFFFFF to addr 4, be 1111, then assert rst=0 during BUSY -> after reset all outputs are 0 and req_ready=1; a load of addr 4 returns the preloaded value.
- Back-to-back requests with req_valid held high and resp_ready=1, LATENCY=1 -> accepts occur every 3 cycles; responses appear in order with correct data.
